// File: rtl/irq_sequencer_pkg.sv
// Shared constants for the vectored interrupt sequencer: default sizes,
// vector layout and FSM state encoding.
package irq_sequencer_pkg;

    localparam int          DEF_NUM_IRQ    = 3;
    localparam int          DEF_ADDR_BITS  = 32;
    localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0800;
    localparam logic [31:0] DEF_VEC_STRIDE = 32'h0000_0100;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_SERVICE = 1'b1;

    // Width of a line index; a single-line build still needs one bit.
    function automatic int sel_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_sequencer_if.sv
// Bundle between the core's PC path and the interrupt sequencer; the core
// side is the master, the sequencer the slave.
interface irq_sequencer_if
    import irq_sequencer_pkg::*;
#(
    parameter int NUM_IRQ   = DEF_NUM_IRQ,
    parameter int ADDR_BITS = DEF_ADDR_BITS
);
    // There is no valid/ready pair: pc_en is the only qualifier. A redirect
    // (vector take or ERET return) happens only in a cycle with pc_en=1, and
    // pc_redirect is valid combinationally in that same cycle; the core must
    // load pc_redirect_addr on that edge instead of pc_next.
    logic [NUM_IRQ-1:0]   irq_in;
    logic                 pc_en;
    logic [ADDR_BITS-1:0] pc_next;
    logic                 eret;
    logic                 mask_we;
    logic [NUM_IRQ-1:0]   mask_wdata;
    logic                 pc_redirect;
    logic [ADDR_BITS-1:0] pc_redirect_addr;
    logic [ADDR_BITS-1:0] epc;
    logic [NUM_IRQ-1:0]   pending;
    logic [NUM_IRQ-1:0]   in_service;
    logic [31:0]          irq_count;
    logic [0:0]           state_dbg;
    logic [NUM_IRQ-1:0]   mask_dbg;

    modport master (
        output irq_in, pc_en, pc_next, eret, mask_we, mask_wdata,
        input  pc_redirect, pc_redirect_addr, epc, pending, in_service,
               irq_count, state_dbg, mask_dbg
    );

    modport slave (
        input  irq_in, pc_en, pc_next, eret, mask_we, mask_wdata,
        output pc_redirect, pc_redirect_addr, epc, pending, in_service,
               irq_count, state_dbg, mask_dbg
    );

endinterface

// File: rtl/irq_sequencer_edge_capture.sv
// Rising-edge detector per interrupt line feeding a pending latch; a new
// edge wins over a clear of the same bit in the same cycle.
module irq_edge_capture
    import irq_sequencer_pkg::*;
#(
    parameter int NUM_IRQ = DEF_NUM_IRQ
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] clr_onehot,
    output logic [NUM_IRQ-1:0] pending
);

    logic [NUM_IRQ-1:0] irq_prev;
    logic [NUM_IRQ-1:0] rise;

    assign rise = irq_in & ~irq_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_prev <= '0;
            pending  <= '0;
        end else begin
            irq_prev <= irq_in;
            pending  <= (pending & ~clr_onehot) | rise;
        end
    end

endmodule

// File: rtl/irq_sequencer.sv
// Vectored interrupt sequencer: picks the highest-priority enabled pending
// line at an instruction boundary, redirects the PC and tracks EPC / ERET.
module irq_sequencer
    import irq_sequencer_pkg::*;
#(
    parameter int                   NUM_IRQ    = DEF_NUM_IRQ,
    parameter int                   ADDR_BITS  = DEF_ADDR_BITS,
    parameter logic [ADDR_BITS-1:0] VEC_BASE   = ADDR_BITS'(DEF_VEC_BASE),
    parameter logic [ADDR_BITS-1:0] VEC_STRIDE = ADDR_BITS'(DEF_VEC_STRIDE)
) (
    input  logic            clk,
    input  logic            rst,
    irq_sequencer_if.slave  bus
);

    localparam int SEL_W = sel_bits(NUM_IRQ);

    logic [0:0]           state;
    logic [NUM_IRQ-1:0]   mask;
    logic [NUM_IRQ-1:0]   pending;
    logic [NUM_IRQ-1:0]   eligible;
    logic [NUM_IRQ-1:0]   sel_onehot;
    logic [NUM_IRQ-1:0]   clr_onehot;
    logic [NUM_IRQ-1:0]   in_service;
    logic [SEL_W-1:0]     sel;
    logic                 take;
    logic                 ret;
    logic [ADDR_BITS-1:0] epc;
    logic [ADDR_BITS-1:0] vec_addr;
    logic [31:0]          irq_count;

    irq_edge_capture #(.NUM_IRQ(NUM_IRQ)) u_edge_capture (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (bus.irq_in),
        .clr_onehot (clr_onehot),
        .pending    (pending)
    );

    // Lowest index wins, so scan downwards and let the last hit stand.
    always_comb begin
        eligible = pending & mask;
        sel      = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) sel = SEL_W'(i);
        end
    end

    // Redirect depends only on state, pc_en, eret and eligible, never pc_next.
    assign take       = !rst && (state == ST_IDLE) && bus.pc_en && (|eligible);
    assign ret        = !rst && (state == ST_SERVICE) && bus.pc_en && bus.eret;
    assign sel_onehot = NUM_IRQ'(1) << sel;
    assign clr_onehot = take ? sel_onehot : '0;
    assign vec_addr   = VEC_BASE + ADDR_BITS'(sel) * VEC_STRIDE;

    assign bus.pc_redirect      = take | ret;
    assign bus.pc_redirect_addr = ret ? epc : vec_addr;
    assign bus.epc              = epc;
    assign bus.pending          = pending;
    assign bus.in_service       = in_service;
    assign bus.irq_count        = irq_count;
    assign bus.state_dbg        = state;
    assign bus.mask_dbg         = mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            mask       <= '1;
            epc        <= '0;
            in_service <= '0;
            irq_count  <= '0;
        end else begin
            if (bus.mask_we) mask <= bus.mask_wdata;
            if (take) begin
                state      <= ST_SERVICE;
                epc        <= bus.pc_next;
                in_service <= sel_onehot;
                irq_count  <= irq_count + 32'd1;
            end else if (ret) begin
                state      <= ST_IDLE;
                in_service <= '0;
            end
        end
    end

endmodule

// File: tb/tb_irq_sequencer.sv
// Self-checking bench for irq_sequencer: directed vector table, then random
// traffic against a behavioural model of the interrupt rules.
module tb_irq_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  irq_sequencer_if #(.NUM_IRQ(3), .ADDR_BITS(32)) bus ();

  irq_sequencer #(.NUM_IRQ(3), .ADDR_BITS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst;
    logic [2:0]  irq;
    logic        pc_en;
    logic [31:0] pc_next;
    logic        eret;
    logic        mask_we;
    logic [2:0]  mask_wdata;
    logic        e_redir;
    logic [31:0] e_addr;
    logic [2:0]  e_pend;
    logic [2:0]  e_insvc;
    logic [31:0] e_epc;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vq[$];
  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // behavioural model state
  logic [2:0]  m_prev, m_pend, m_mask;
  logic [31:0] m_epc, m_cnt;
  int          m_serving;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic row(input logic r, input logic [2:0] irq, input logic en, input logic [31:0] pn,
                     input logic er, input logic we, input logic [2:0] wd, input logic e_redir,
                     input logic [31:0] e_addr, input logic [2:0] e_pend, input logic [2:0] e_insvc,
                     input logic [31:0] e_epc, input logic [31:0] e_cnt);
    vec_t v;
    v = '{r, irq, en, pn, er, we, wd, e_redir, e_addr, e_pend, e_insvc, e_epc, e_cnt};
    vq.push_back(v);
  endtask

  task automatic drive(input logic r, input logic [2:0] irq, input logic en, input logic [31:0] pn,
                       input logic er, input logic we, input logic [2:0] wd);
    @(negedge clk);
    rst            = r;
    bus.irq_in     = irq;
    bus.pc_en      = en;
    bus.pc_next    = pn;
    bus.eret       = er;
    bus.mask_we    = we;
    bus.mask_wdata = wd;
    #1;
  endtask

  // One random cycle: predict from the rules, compare, then advance the model.
  task automatic rand_step();
    logic        r, en, er, we, take, ret;
    logic [2:0]  irq, wd, elig, clr, rise;
    logic [31:0] pn, exp_addr;
    int          sel;
    r   = ($urandom_range(0, 99) == 0);
    irq = bus.irq_in ^ (3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7)));
    en  = ($urandom_range(0, 3) != 0);
    er  = ($urandom_range(0, 3) == 0);
    we  = ($urandom_range(0, 9) == 0);
    wd  = 3'($urandom_range(0, 7));
    pn  = $urandom;
    drive(r, irq, en, pn, er, we, wd);

    elig = m_pend & m_mask;
    sel  = -1;
    for (int i = 0; i < 3; i++) if (sel < 0 && elig[i]) sel = i;
    take = !r && (m_serving < 0) && en && (sel >= 0);
    ret  = !r && (m_serving >= 0) && en && er;
    exp_addr = take ? (32'h800 + 32'(sel) * 32'h100) : m_epc;
    if (take || ret) exp_q.push_back(exp_addr);

    chk("rnd_redirect", 32'(bus.pc_redirect), 32'(take || ret));
    if (bus.pc_redirect) begin
      if (exp_q.size() == 0) chk("rnd_addr_unexpected", bus.pc_redirect_addr, 32'hffff_ffff);
      else chk("rnd_addr", bus.pc_redirect_addr, exp_q.pop_front());
    end
    chk("rnd_pending", 32'(bus.pending), 32'(m_pend));
    chk("rnd_in_service", 32'(bus.in_service), (m_serving < 0) ? 32'd0 : (32'd1 << m_serving));
    chk("rnd_epc", bus.epc, m_epc);
    chk("rnd_count", bus.irq_count, m_cnt);
    chk("rnd_mask", 32'(bus.mask_dbg), 32'(m_mask));
    chk("rnd_state", 32'(bus.state_dbg), 32'(m_serving >= 0));

    if (r) begin
      m_prev = 3'b000; m_pend = 3'b000; m_mask = 3'b111;
      m_epc = 0; m_cnt = 0; m_serving = -1;
    end else begin
      rise = irq & ~m_prev;
      m_prev = irq;
      clr = 3'b000;
      if (take) begin
        m_epc = pn;
        m_cnt = m_cnt + 1;
        m_serving = sel;
        clr[sel] = 1'b1;
      end else if (ret) begin
        m_serving = -1;
      end
      m_pend = (m_pend & ~clr) | rise;
      if (we) m_mask = wd;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    bus.irq_in = 3'b000; bus.pc_en = 1'b0; bus.pc_next = '0;
    bus.eret = 1'b0; bus.mask_we = 1'b0; bus.mask_wdata = 3'b000;

    // reset for two cycles, then ten idle cycles with pc_en held
    drive(1'b1, 3'b000, 1'b1, 32'h0, 1'b0, 1'b0, 3'b000);
    chk("reset_redirect_gated", 32'(bus.pc_redirect), 32'd0);
    drive(1'b1, 3'b000, 1'b1, 32'h0, 1'b0, 1'b0, 3'b000);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 3'b000, 1'b1, 32'h10 + 32'(i * 4), 1'b0, 1'b0, 3'b000);
      chk("idle_redirect", 32'(bus.pc_redirect), 32'd0);
      chk("idle_pending", 32'(bus.pending), 32'd0);
      if (i == 0) begin
        chk("reset_mask", 32'(bus.mask_dbg), 32'h7);
        chk("reset_state", 32'(bus.state_dbg), 32'd0);
        chk("reset_epc", bus.epc, 32'd0);
        chk("reset_in_service", 32'(bus.in_service), 32'd0);
        chk("reset_count", bus.irq_count, 32'd0);
      end
    end

    //   rst irq     en pc_next  er we wd      red addr      pend    insvc   epc      cnt
    row(0, 3'b010, 1, 32'h040, 0, 0, 3'b000, 0, 32'h000, 3'b000, 3'b000, 32'h000, 0);
    row(0, 3'b000, 1, 32'h040, 0, 0, 3'b000, 1, 32'h900, 3'b010, 3'b000, 32'h000, 0);
    row(0, 3'b000, 1, 32'h044, 0, 0, 3'b000, 0, 32'h000, 3'b000, 3'b010, 32'h040, 1);
    row(0, 3'b000, 1, 32'h048, 1, 0, 3'b000, 1, 32'h040, 3'b000, 3'b010, 32'h040, 1);
    row(0, 3'b101, 0, 32'h04c, 0, 0, 3'b000, 0, 32'h000, 3'b000, 3'b000, 32'h040, 1);
    row(0, 3'b101, 1, 32'h080, 0, 0, 3'b000, 1, 32'h800, 3'b101, 3'b000, 32'h040, 1);
    row(0, 3'b000, 1, 32'h084, 0, 0, 3'b000, 0, 32'h000, 3'b100, 3'b001, 32'h080, 2);
    row(0, 3'b000, 1, 32'h088, 1, 0, 3'b000, 1, 32'h080, 3'b100, 3'b001, 32'h080, 2);
    row(0, 3'b000, 1, 32'h0c0, 0, 0, 3'b000, 1, 32'ha00, 3'b100, 3'b000, 32'h080, 2);
    row(0, 3'b000, 1, 32'h0c4, 1, 0, 3'b000, 1, 32'h0c0, 3'b000, 3'b100, 32'h0c0, 3);
    row(0, 3'b001, 0, 32'h0c8, 0, 0, 3'b000, 0, 32'h000, 3'b000, 3'b000, 32'h0c0, 3);
    row(0, 3'b000, 0, 32'h0c8, 0, 1, 3'b110, 0, 32'h000, 3'b001, 3'b000, 32'h0c0, 3);
    row(0, 3'b000, 1, 32'h100, 0, 0, 3'b000, 0, 32'h000, 3'b001, 3'b000, 32'h0c0, 3);
    row(0, 3'b000, 1, 32'h100, 0, 1, 3'b111, 0, 32'h000, 3'b001, 3'b000, 32'h0c0, 3);
    row(0, 3'b000, 1, 32'h104, 0, 0, 3'b000, 1, 32'h800, 3'b001, 3'b000, 32'h0c0, 3);
    row(0, 3'b001, 1, 32'h108, 0, 0, 3'b000, 0, 32'h000, 3'b000, 3'b001, 32'h104, 4);
    row(0, 3'b000, 1, 32'h108, 0, 0, 3'b000, 0, 32'h000, 3'b001, 3'b001, 32'h104, 4);
    row(0, 3'b000, 0, 32'h108, 1, 0, 3'b000, 0, 32'h000, 3'b001, 3'b001, 32'h104, 4);
    row(0, 3'b000, 1, 32'h10c, 1, 0, 3'b000, 1, 32'h104, 3'b001, 3'b001, 32'h104, 4);
    row(0, 3'b001, 1, 32'h200, 0, 0, 3'b000, 1, 32'h800, 3'b001, 3'b000, 32'h104, 4);
    row(0, 3'b000, 1, 32'h204, 1, 0, 3'b000, 1, 32'h200, 3'b001, 3'b001, 32'h200, 5);
    row(0, 3'b000, 1, 32'h300, 0, 0, 3'b000, 1, 32'h800, 3'b001, 3'b000, 32'h200, 5);
    row(1, 3'b000, 1, 32'h304, 1, 0, 3'b000, 0, 32'h000, 3'b000, 3'b001, 32'h300, 6);
    row(0, 3'b000, 1, 32'h310, 1, 0, 3'b000, 0, 32'h000, 3'b000, 3'b000, 32'h000, 0);

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      drive(v.rst, v.irq, v.pc_en, v.pc_next, v.eret, v.mask_we, v.mask_wdata);
      chk($sformatf("vec%0d_redirect", i), 32'(bus.pc_redirect), 32'(v.e_redir));
      if (v.e_redir) chk($sformatf("vec%0d_addr", i), bus.pc_redirect_addr, v.e_addr);
      chk($sformatf("vec%0d_pending", i), 32'(bus.pending), 32'(v.e_pend));
      chk($sformatf("vec%0d_in_service", i), 32'(bus.in_service), 32'(v.e_insvc));
      chk($sformatf("vec%0d_epc", i), bus.epc, v.e_epc);
      chk($sformatf("vec%0d_count", i), bus.irq_count, v.e_cnt);
    end
    chk("post_table_state", 32'(bus.state_dbg), 32'd0);
    chk("post_table_mask", 32'(bus.mask_dbg), 32'h7);

    // model starts from the idle, cleared state the table leaves behind
    m_prev = 3'b000; m_pend = 3'b000; m_mask = 3'b111;
    m_epc = 0; m_cnt = 0; m_serving = -1;
    for (int n = 0; n < 600; n++) rand_step();
    chk("addr_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
